// File: rtl/step_controller.sv
// step_controller: sequences processor enables for single-step, continuous run and halt.
module step_controller #(
  parameter int RATE_DIV = 4,
  parameter int COUNT_W  = 16
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               StepPulse,
  input  logic               RunPulse,
  input  logic               ResumePulse,
  input  logic               HaltIn,
  output logic               CpuEn,
  output logic               Running,
  output logic               Halted,
  output logic [COUNT_W-1:0] IssueCount
);
  localparam int DIV_W = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(RATE_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] div, div_nx;
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state      <= IDLE;
      div        <= '0;
      IssueCount <= '0;
    end else begin
      state <= state_nx;
      div   <= div_nx;
      if (CpuEn && IssueCount != '1) IssueCount <= IssueCount + COUNT_W'(1);
    end
  end
  always_comb begin
    state_nx = state;
    div_nx   = '0;
    CpuEn    = 1'b0;
    Running  = state == RUN;
    Halted   = state == HALT;
    case (state)
      IDLE: state_nx = RunPulse ? RUN : StepPulse ? STEP : IDLE;
      STEP: begin
        CpuEn    = 1'b1;
        state_nx = IDLE;
      end
      RUN: begin
        CpuEn    = div == LAST;
        state_nx = RunPulse ? IDLE : RUN;
        div_nx   = (RunPulse || div == LAST) ? '0 : div + DIV_W'(1);
      end
      HALT: state_nx = (ResumePulse && !HaltIn) ? IDLE : HALT;
      default: state_nx = IDLE;
    endcase
    // a halt from the processor overrides every pulse and suppresses the enable
    if (HaltIn) begin
      CpuEn = 1'b0;
      if (state != HALT) begin
        state_nx = HALT;
        div_nx   = '0;
      end
    end
  end
endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: randomized scoreboard bench for two step_controller configurations.
module tb_step_controller;
  logic clk = 1'b0;
  logic rstn = 1'b0, step = 1'b0, run = 1'b0, resume = 1'b0, halt = 1'b0;
  logic en0, running0, halted0, en1, running1, halted1;
  logic [15:0] cnt0;
  logic [3:0] cnt1;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  step_controller #(.RATE_DIV(4), .COUNT_W(16)) u0 (
    .Clk(clk), .ResetN(rstn), .StepPulse(step), .RunPulse(run), .ResumePulse(resume),
    .HaltIn(halt), .CpuEn(en0), .Running(running0), .Halted(halted0), .IssueCount(cnt0));
  step_controller #(.RATE_DIV(1), .COUNT_W(4)) u1 (
    .Clk(clk), .ResetN(rstn), .StepPulse(step), .RunPulse(run), .ResumePulse(resume),
    .HaltIn(halt), .CpuEn(en1), .Running(running1), .Halted(halted1), .IssueCount(cnt1));
  typedef struct {bit chk; bit en; bit running; bit halted; int cnt;} exp_t;
  exp_t q0[$], q1[$];
  localparam int M_IDLE = 0, M_STEP = 1, M_RUN = 2, M_HALT = 3;
  int rate[2] = '{4, 1};
  int maxc[2] = '{65535, 15};
  int mode[2], run_t[2], count[2];
  bit known[2] = '{0, 0};
  function automatic void model(input int k, input bit s, input bit r, input bit rs, input bit h, input bit rn);
    exp_t e;
    e.chk     = known[k];
    e.en      = !h && (mode[k] == M_STEP || (mode[k] == M_RUN && run_t[k] % rate[k] == rate[k] - 1));
    e.running = mode[k] == M_RUN;
    e.halted  = mode[k] == M_HALT;
    e.cnt     = count[k];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    if (!rn) begin
      mode[k] = M_IDLE; run_t[k] = 0; count[k] = 0; known[k] = 1;
    end else if (known[k]) begin
      if (e.en && count[k] < maxc[k]) count[k]++;
      if (h && mode[k] != M_HALT) mode[k] = M_HALT;
      else if (mode[k] == M_IDLE) begin
        if (r) begin mode[k] = M_RUN; run_t[k] = 0; end
        else if (s) mode[k] = M_STEP;
      end else if (mode[k] == M_STEP) mode[k] = M_IDLE;
      else if (mode[k] == M_RUN) begin
        if (r) mode[k] = M_IDLE; else run_t[k]++;
      end else if (rs && !h) mode[k] = M_IDLE;
    end
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      if (e.chk) begin
        check("cpu_en_r4", int'(en0), int'(e.en));
        check("running_r4", int'(running0), int'(e.running));
        check("halted_r4", int'(halted0), int'(e.halted));
        check("issue_count_r4", int'(cnt0), e.cnt);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      if (e.chk) begin
        check("cpu_en_r1", int'(en1), int'(e.en));
        check("running_r1", int'(running1), int'(e.running));
        check("halted_r1", int'(halted1), int'(e.halted));
        check("issue_count_r1", int'(cnt1), e.cnt);
      end
    end
  end
  task automatic cyc(input bit s, input bit r, input bit rs, input bit h, input bit rn);
    @(posedge clk);
    #1;
    step = s; run = r; resume = rs; halt = h; rstn = rn;
    model(0, s, r, rs, h, rn);
    model(1, s, r, rs, h, rn);
  endtask
  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, h, 1);
  endtask
  initial begin
    bit h;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    idle(8, 0);
    cyc(1, 0, 0, 0, 1);
    idle(4, 0);
    cyc(0, 1, 0, 0, 1);
    idle(12, 0);
    cyc(0, 1, 0, 0, 1);
    idle(3, 0);
    cyc(0, 1, 0, 0, 1);
    idle(3, 0);
    cyc(0, 0, 0, 1, 1);
    idle(2, 1);
    cyc(0, 0, 1, 1, 1);
    idle(2, 1);
    idle(1, 0);
    cyc(0, 0, 1, 0, 1);
    idle(2, 0);
    cyc(1, 1, 0, 0, 1);
    idle(2, 0);
    cyc(0, 1, 0, 0, 1);
    idle(2, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    idle(2, 0);
    cyc(0, 1, 0, 0, 1);
    idle(22, 0);
    cyc(0, 0, 0, 0, 0);
    idle(2, 0);
    cyc(0, 1, 0, 0, 1);
    idle(20, 0);
    cyc(0, 1, 0, 0, 1);
    idle(2, 0);
    h = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) h = !h;
      cyc($urandom_range(7) == 0, $urandom_range(11) == 0, $urandom_range(5) == 0, h,
          $urandom_range(299) != 0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
